// File: rtl/md_if.sv
// md_if: EX-stage multiply/divide request/response bundle between pipeline (master) and unit (slave).
interface md_if #(parameter int XLEN = 32);
  logic            start;
  logic            kill;
  logic [2:0]      mul_mode;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, kill, mul_mode, src1, src2, input busy, done, result);
  modport slave  (input start, kill, mul_mode, src1, src2, output busy, done, result);
endinterface

// File: rtl/md_exec_unit.sv
// md_exec_unit: iterative RV32M multiply/divide unit (IDLE->CALC->FIX->DONE).
// MD_FAST_MUL_EN selects a single-cycle multiplier for modes 0-3.
module md_exec_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  md_if.slave m
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t              r_state, w_next;
  logic [2:0]          r_mode;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b, r_result;
  logic                r_neg, r_rneg;
  logic                w_div, w_s1, w_s2, w_dz, w_ovf, w_fast, w_ge;
  logic [XLEN-1:0]     w_a1, w_a2, w_diff, w_quo, w_remv, w_sel;
  logic [XLEN:0]       w_msum, w_rem;
  logic [2*XLEN-1:0]   w_fprod, w_init, w_step, w_prod;
`ifdef MD_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
  assign w_fprod = {{XLEN{1'b0}}, w_a1} * {{XLEN{1'b0}}, w_a2};
`else
  localparam logic FAST_MUL = 1'b0;
  assign w_fprod = '0;
`endif
  assign w_div  = m.mul_mode[2];
  assign w_s1   = m.src1[XLEN-1] & (m.mul_mode == 3'd1 || m.mul_mode == 3'd2 || m.mul_mode == 3'd4 || m.mul_mode == 3'd6);
  assign w_s2   = m.src2[XLEN-1] & (m.mul_mode == 3'd1 || m.mul_mode == 3'd4 || m.mul_mode == 3'd6);
  assign w_a1   = w_s1 ? -m.src1 : m.src1;
  assign w_a2   = w_s2 ? -m.src2 : m.src2;
  assign w_dz   = w_div & (m.src2 == '0);
  assign w_ovf  = (m.mul_mode == 3'd4 || m.mul_mode == 3'd6) & (m.src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&m.src2);
  assign w_fast = w_dz | w_ovf | (FAST_MUL & ~w_div);
  // Fast paths preload the accumulator so FIX selects them like any other {remainder, quotient} / product.
  assign w_init = w_dz  ? {m.src1, {XLEN{1'b1}}} :
                  w_ovf ? {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}} :
                  w_div ? {{XLEN{1'b0}}, w_a1} :
                  FAST_MUL ? w_fprod : {{XLEN{1'b0}}, w_a2};
  assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_acc[0] ? r_b : {XLEN{1'b0}}};
  assign w_rem  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge   = w_rem >= {1'b0, r_b};
  assign w_diff = w_rem[XLEN-1:0] - r_b;
  assign w_step = r_mode[2] ? {w_ge ? w_diff : w_rem[XLEN-1:0], r_acc[XLEN-2:0], w_ge}
                            : {w_msum, r_acc[XLEN-1:1]};
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_remv = r_rneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_sel  = (r_mode == 3'd0) ? w_prod[XLEN-1:0] :
                  !r_mode[2] ? w_prod[2*XLEN-1:XLEN] :
                  !r_mode[1] ? w_quo : w_remv;
  always_comb begin
    w_next = r_state;
    if (m.kill) w_next = IDLE;
    else if (r_state == IDLE) w_next = m.start ? (w_fast ? FIX : CALC) : IDLE;
    else if (r_state == CALC) w_next = (r_cnt == CNT_W'(XLEN-1)) ? FIX : CALC;
    else if (r_state == FIX) w_next = DONE;
    else w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mode   <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && m.start && !m.kill) begin
        r_mode <= m.mul_mode;
        r_cnt  <= '0;
        r_acc  <= w_init;
        r_b    <= w_div ? w_a2 : w_a1;
        r_neg  <= ~(w_dz | w_ovf) & (w_s1 ^ w_s2);
        r_rneg <= ~(w_dz | w_ovf) & w_s1;
      end else if (r_state == CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == FIX && !m.kill) r_result <= w_sel;
    end
  end
  assign m.busy   = (r_state != IDLE);
  assign m.done   = (r_state == DONE);
  assign m.result = r_result;
endmodule

// File: tb/tb_md_exec_unit.sv
// tb_md_exec_unit: scoreboard bench for md_exec_unit; arithmetic reference model, directed and random ops.
module tb_md_exec_unit;
  typedef struct {
    logic [31:0] res;
    int          lat;
    int          st;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] last_res = '0;
  exp_t sb[$];
  exp_t e;
  md_if bus ();
  md_exec_unit dut (.clk(clk), .rst(rst), .m(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] model_res(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb2 = longint'(signed'(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (md)
      3'd0: begin p = sa * sb2; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb2; return p[31:0]; end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin if (b == 0) return a; p = sa % sb2; return p[31:0]; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic int model_lat(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    if (md[2]) return (b == 0 || ((md == 3'd4 || md == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 2 : 34;
`ifdef MD_FAST_MUL_EN
    return 2;
`else
    return 34;
`endif
  endfunction
  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 result=%h expected no done (cycle %0d)", bus.result, cyc);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("latency", 32'(cyc - e.st), 32'(e.lat));
        last_res = e.res;
      end
    end
  end
  task automatic launch(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    sb.push_back('{model_res(md, a, b), model_lat(md, a, b), cyc});
    bus.mul_mode = md;
    bus.src1 = a;
    bus.src2 = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mul_mode = 3'($urandom);
    bus.src1 = $urandom;
    bus.src2 = $urandom;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done after %0d cycles expected done", n);
      sb.delete();
    end
  endtask
  task automatic run(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    launch(md, a, b);
    wait_idle();
  endtask
  initial begin
    int st;
    int n;
    logic [2:0] md;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.mul_mode = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    run(3'd0, 32'd7, 32'hFFFFFFFD);
    run(3'd1, 32'h80000000, 32'h80000000);
    run(3'd3, 32'h80000000, 32'h80000000);
    run(3'd2, 32'h80000000, 32'h80000000);
    run(3'd5, 32'd100, 32'd7);
    run(3'd7, 32'd100, 32'd7);
    run(3'd6, 32'hFFFFFFF9, 32'd2);
    run(3'd4, 32'hFFFFFFF9, 32'd2);
    run(3'd4, 32'd5, 32'd0);
    run(3'd6, 32'd5, 32'd0);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF);
    run(3'd5, 32'd100, 32'd7);
    // Killed DIVU: no done, result stays, restart right after the flush.
    @(negedge clk);
    st = cyc;
    bus.mul_mode = 3'd5;
    bus.src1 = 32'd12345;
    bus.src2 = 32'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < st + 10) @(negedge clk);
    chk("busy_before_kill", 32'(bus.busy), 32'd1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill_busy", 32'(bus.busy), 32'd0);
    chk("kill_result", bus.result, last_res);
    launch(3'd5, 32'd1000, 32'd9);
    wait_idle();
    // Start held through a whole MUL must yield a single done.
    @(negedge clk);
    sb.push_back('{model_res(3'd0, 32'd7, 32'hFFFFFFFD), model_lat(3'd0, 32'd7, 32'hFFFFFFFD), cyc});
    bus.mul_mode = 3'd0;
    bus.src1 = 32'd7;
    bus.src2 = 32'hFFFFFFFD;
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL held_start_timeout: got no done expected done");
      sb.delete();
    end
    repeat (40) @(negedge clk);
    run(3'd5, 32'd100, 32'd7);
    // Reset mid-divide clears everything.
    @(negedge clk);
    st = cyc;
    launch(3'd5, 32'd1000, 32'd3);
    while (cyc < st + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    sb.delete();
    rst = 1'b0;
    run(3'd7, 32'd1000, 32'd7);
    for (int i = 0; i < 300; i++) begin
      md = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run(md, a, b);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
